// File: rtl/cv32e40p_bht_predictor.sv
// Tagged branch history table with per-entry target (BTB).
// Sweep FSM initialises storage after reset or flush.
module cv32e40p_bht_predictor #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 2,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    output logic        ready_o,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic [31:0] update_target_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             r_ready;
    logic             w_sweep;

    logic             r_valid [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [CNT_W-1:0] r_cnt   [DEPTH];
    logic [30:0]      r_tgt   [DEPTH];

    logic [IDX_W-1:0] w_lidx;
    logic [TAG_W-1:0] w_ltag;
    logic             w_lhit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic [CNT_W-1:0] w_ucnt;

    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    logic             w_wvalid;
    logic [TAG_W-1:0] w_wtag;
    logic [CNT_W-1:0] w_wcnt;
    logic [30:0]      w_wtgt;
    logic             w_unused;

    assign w_lidx = lookup_pc_i[IDX_W+1:2];
    assign w_ltag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_uidx = update_pc_i[IDX_W+1:2];
    assign w_utag = update_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ucnt = r_cnt[w_uidx];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_unused = ^{lookup_pc_i, update_pc_i, update_target_i[0]};

    // State, sweep pointer and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

    // Next state: flush always restarts the sweep
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (flush_i) begin
            w_state_nxt = S_INIT;
            w_ptr_nxt   = '0;
        end else if (r_state == S_INIT) begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == LAST) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    // FSM outputs
    always_comb begin
        w_sweep = (r_state == S_INIT);
        ready_o = r_ready;
    end

    // Single write port: sweep init or branch update
    always_comb begin
        w_we     = 1'b0;
        w_widx   = r_ptr;
        w_wvalid = 1'b0;
        w_wtag   = '0;
        w_wcnt   = CNT_WNT;
        w_wtgt   = '0;
        if (w_sweep) begin
            w_we = 1'b1;
        end else if (update_valid_i && !flush_i) begin
            w_widx   = w_uidx;
            w_wvalid = 1'b1;
            w_wtag   = w_utag;
            if (w_uhit) begin
                w_we = 1'b1;
                if (update_taken_i) begin
                    w_wcnt = (w_ucnt == CNT_MAX) ? w_ucnt : w_ucnt + 1'b1;
                    w_wtgt = update_target_i[31:1];
                end else begin
                    w_wcnt = (w_ucnt == CNT_MIN) ? w_ucnt : w_ucnt - 1'b1;
                    w_wtgt = r_tgt[w_uidx];
                end
            end else if (update_taken_i) begin
                w_we   = 1'b1;
                w_wcnt = CNT_WT;
                w_wtgt = update_target_i[31:1];
            end
        end
    end

    // Table storage, no reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_valid[w_widx] <= w_wvalid;
            r_tag[w_widx]   <= w_wtag;
            r_cnt[w_widx]   <= w_wcnt;
            r_tgt[w_widx]   <= w_wtgt;
        end
    end

    // Lookup, gated by ready so uninitialised storage never leaks
    always_comb begin
        w_lhit = r_ready && lookup_valid_i && r_valid[w_lidx]
                 && (r_tag[w_lidx] == w_ltag);
        pred_hit_o    = w_lhit;
        pred_taken_o  = w_lhit && r_cnt[w_lidx][CNT_W-1];
        pred_target_o = w_lhit ? {r_tgt[w_lidx], 1'b0} : 32'h0;
    end

endmodule
